phase_sequencer: RTL

Generates the 3-bit `phase` code and run state consumed by `control_unit`, which decodes it into the one-hot phase enables `p1`..`p5`. Turns the raw `exec` and `step` push-buttons into clean single-cycle requests and runs a phase counter 0..NUM_PHASES-1. Starts, stops, single-steps and halts only on instruction boundaries. Counts retired instructions.

---
 rtl/phase_pkg.sv | 30 +++
 rtl/phase_sequencer_if.sv | 41 ++++
 rtl/button_sync.sv | 43 ++++
 rtl/phase_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/phase_pkg.sv
// ---------------------------------------------------------------------------
// phase_pkg
// Shared definitions for the instruction phase sequencer and control_unit:
//   - seq_state_t : sequencer run state encoding (IDLE, RUN, STEP, HALTED)
//   - DEFAULT_NUM_PHASES : phases per instruction for the standard pipeline
//   - PH_* : named phase codes decoded by control_unit into p1..p5
// ---------------------------------------------------------------------------
package phase_pkg;

    localparam int DEFAULT_NUM_PHASES = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_DECODE = 3'd1;
    localparam logic [2:0] PH_EXEC   = 3'd2;
    localparam logic [2:0] PH_MEM    = 3'd3;
    localparam logic [2:0] PH_WB     = 3'd4;

    // True when the sequencer is issuing phases to control_unit.
    function automatic logic is_active(input seq_state_t st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// phase_sequencer_if
// Groups the sequencer's control inputs and status outputs.
//   master : the environment side (buttons, execute stage, stall source)
//   slave  : the phase_sequencer itself
// Signals:
//   exec, step   raw asynchronous push-button levels
//   halt         "halt instruction executed" level from execute stage
//   stall        holds the phase counter while high
//   phase        current phase code
//   running      qualifies phase for control_unit
//   halted       sticky halt indicator
//   boundary     one-cycle pulse when phase wraps to 0
//   instr_count  retired-instruction count
// ---------------------------------------------------------------------------
interface phase_sequencer_if #(
    parameter int PHASE_W = 3,
    parameter int COUNT_W = 16
);

    logic               exec;
    logic               step;
    logic               halt;
    logic               stall;
    logic [PHASE_W-1:0] phase;
    logic               running;
    logic               halted;
    logic               boundary;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        output exec, step, halt, stall,
        input  phase, running, halted, boundary, instr_count
    );

    modport slave (
        input  exec, step, halt, stall,
        output phase, running, halted, boundary, instr_count
    );

endinterface

// File: rtl/button_sync.sv
// ---------------------------------------------------------------------------
// button_sync
// Brings an asynchronous push-button level into the clock domain through a
// SYNC_STAGES flop chain, then produces a registered one-cycle pulse on its
// rising edge. A button held for any length of time yields a single pulse.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset
//   raw    asynchronous button level
//   pulse  registered one-cycle rising-edge pulse
// ---------------------------------------------------------------------------
module button_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   pulse_r;

    // Synchronizer chain, previous-level history and registered edge pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r  <= '0;
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            sync_r[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r  <= sync_r[SYNC_STAGES-1];
            pulse_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// Produces the phase code and run state consumed by control_unit. The exec
// and step buttons are cleaned into single-cycle requests; a phase counter
// runs 0..NUM_PHASES-1 while RUN or STEP is active. Start, stop, single-step
// and halt all take effect only on instruction boundaries, so control_unit
// never sees a partial instruction. Retired instructions are counted.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset, clears all state
//   bus    phase_sequencer_if.slave (exec, step, halt, stall in;
//          phase, running, halted, boundary, instr_count out)
// ---------------------------------------------------------------------------
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int NUM_PHASES  = DEFAULT_NUM_PHASES,
    parameter int PHASE_W     = 3,
    parameter int COUNT_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    phase_sequencer_if.slave  bus
);

    localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(NUM_PHASES - 1);
    localparam logic [PHASE_W-1:0] FIRST_PHASE = PHASE_W'(PH_FETCH);

    seq_state_t         state_r;
    logic [PHASE_W-1:0] phase_r;
    logic               running_r;
    logic               halted_r;
    logic               boundary_r;
    logic [COUNT_W-1:0] count_r;
    logic               stop_req_r;
    logic               halt_req_r;

    logic               exec_pulse_s;
    logic               step_pulse_s;
    logic               halt_req_s;
    logic               stop_req_s;
    logic               wrap_s;

    button_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_exec_sync (
        .clock (clock),
        .reset (reset),
        .raw   (bus.exec),
        .pulse (exec_pulse_s)
    );

    button_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_step_sync (
        .clock (clock),
        .reset (reset),
        .raw   (bus.step),
        .pulse (step_pulse_s)
    );

    // Request latches merged with this cycle's requests so a request arriving
    // on the wrap cycle itself still acts on that boundary. The >= compare
    // lets an out-of-range phase recover at the next unstalled cycle.
    always_comb begin
        halt_req_s = halt_req_r | bus.halt;
        stop_req_s = stop_req_r | exec_pulse_s;
        if (is_active(state_r) && !bus.stall && (phase_r >= LAST_PHASE)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Run-state FSM with phase counter, request latches and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            phase_r    <= FIRST_PHASE;
            running_r  <= 1'b0;
            halted_r   <= 1'b0;
            boundary_r <= 1'b0;
            count_r    <= '0;
            stop_req_r <= 1'b0;
            halt_req_r <= 1'b0;
        end else begin
            boundary_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    phase_r    <= FIRST_PHASE;
                    stop_req_r <= 1'b0;
                    halt_req_r <= 1'b0;
                    if (exec_pulse_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end else if (step_pulse_s) begin
                        state_r   <= ST_STEP;
                        running_r <= 1'b1;
                    end
                end

                ST_RUN, ST_STEP: begin
                    if (wrap_s) begin
                        // Instruction retires: phase 0, boundary and count
                        // update land on the same edge as any state change.
                        phase_r    <= FIRST_PHASE;
                        boundary_r <= 1'b1;
                        count_r    <= count_r + COUNT_W'(1);
                        if (halt_req_s) begin
                            state_r    <= ST_HALTED;
                            running_r  <= 1'b0;
                            halted_r   <= 1'b1;
                            stop_req_r <= 1'b0;
                            halt_req_r <= 1'b0;
                        end else if ((state_r == ST_STEP) || stop_req_s) begin
                            state_r    <= ST_IDLE;
                            running_r  <= 1'b0;
                            stop_req_r <= 1'b0;
                            halt_req_r <= 1'b0;
                        end
                    end else begin
                        if (!bus.stall) begin
                            phase_r <= phase_r + PHASE_W'(1);
                        end
                        // halt is sampled even in stalled cycles.
                        halt_req_r <= halt_req_s;
                        // Button pulses are ignored while single-stepping.
                        if (state_r == ST_RUN) begin
                            stop_req_r <= stop_req_s;
                        end
                    end
                end

                ST_HALTED: begin
                    phase_r    <= FIRST_PHASE;
                    stop_req_r <= 1'b0;
                    halt_req_r <= 1'b0;
                    if (exec_pulse_s) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                        halted_r  <= 1'b0;
                    end else if (step_pulse_s) begin
                        state_r   <= ST_STEP;
                        running_r <= 1'b1;
                        halted_r  <= 1'b0;
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    phase_r    <= FIRST_PHASE;
                    running_r  <= 1'b0;
                    stop_req_r <= 1'b0;
                    halt_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase       = phase_r;
    assign bus.running     = running_r;
    assign bus.halted      = halted_r;
    assign bus.boundary    = boundary_r;
    assign bus.instr_count = count_r;

endmodule
